apb_req_scheduler: RTL
======================

// Module: apb_req_scheduler
// PURPOSE
//  Shares the 2-slave APB bridge user port (transfer/READ_WRITE/addr/data) between NREQ requesters.
//  Round-robin arbitration, one outstanding APB transfer at a time.
//  Completion detected from the bus (PENABLE & PREADY); per-requester response with read data/error.
//  Bus-hang timeout so a stuck slave never locks out the other requesters.
//  Sits between the requesters and the APB bridge; addr[8] selects slave 0/1 as on the bridge.
// PARAMETERS
//  NREQ            4   number of requesters (2..8)
//  TIMEOUT_CYCLES  16  max cycles in BUSY before abort; 0 = timeout disabled
// PORTS
//  PCLK              in   1         clock, all logic on rising edge
//  PRESETn           in   1         asynchronous active-low reset
//  req_valid         in   NREQ      per-requester request; held until its req_grant is seen
//  req_write         in   NREQ      1 = write, 0 = read
//  req_addr          in   NREQ*9    packed, requester i at [9i+8:9i]
//  req_wdata         in   NREQ*8    packed, requester i at [8i+7:8i]
//  req_grant         out  NREQ      one-hot, 1-cycle pulse: request accepted
//  rsp_valid         out  NREQ      one-hot, 1-cycle pulse: transfer finished
//  rsp_rdata         out  8         read data (0 for writes), valid with rsp_valid
//  rsp_err           out  1         PSLVERR or timeout, valid with rsp_valid
//  rsp_timeout       out  1         abort caused by timeout, valid with rsp_valid
//  transfer          out  1         to bridge: transfer request
//  READ_WRITE        out  1         to bridge: 1 = read, 0 = write
//  apb_write_paddr   out  9         to bridge: write address (0 during reads)
//  apb_write_data    out  8         to bridge: write data (0 during reads)
//  apb_read_paddr    out  9         to bridge: read address (0 during writes)
//  PENABLE           in   1         bus monitor tap
//  PREADY            in   1         bus monitor tap
//  PSLVERR           in   1         bus slave error
//  apb_read_data_out in   8         read data returned by bridge
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = NREQ-1 (requester 0 wins first); timer 0.
//  All outputs registered. FSM IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: transfer=0. On edge with req_valid!=0: pick first set bit searching ptr+1, ptr+2,... mod NREQ;
//   latch write/addr/wdata/index; -> BUSY. req_grant[idx]=1 for the first BUSY cycle only.
//  BUSY: transfer=1; READ_WRITE=~write; addr/data driven from latch per direction, other side 0.
//   timer increments each cycle. Edge with PENABLE&PREADY: capture rsp_rdata (read: apb_read_data_out,
//   write: 0), rsp_err=PSLVERR, rsp_timeout=0; -> RESP.
//   Else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: rsp_rdata=0, rsp_err=1, rsp_timeout=1; -> RESP.
//   Completion and timeout on same edge: completion wins.
//  RESP: transfer=0 (guarantees bridge sees a gap, no back-to-back re-issue); rsp_valid[idx]=1 one cycle;
//   ptr<=idx; timer<=0; -> IDLE. rsp_rdata/err/timeout hold until next RESP.
//  req_valid ignored outside IDLE; min gap between two grants = BUSY length + 2 cycles.
//  Requester must drop req_valid on the cycle its grant is high, or it is re-arbitrated as a new request.
//  Single requester valid: granted regardless of ptr. No requester: stay IDLE, outputs stable.
//  PRESETn low mid-transfer: immediate return to reset values, no rsp_valid for the aborted request.
// STRUCTURE
//  Package apb_sched_pkg: ADDR_W=9, DATA_W=8, RW_READ=1'b1/RW_WRITE=1'b0, state enum {IDLE,BUSY,RESP}.
//  Sub-module rr_arbiter #(N): req vector + last-grant pointer -> one-hot grant + index, combinational.
//  Top holds FSM, request latch, timer, response registers.
// TESTING
//  1 req0 write addr 0x005 data 0xA5, PREADY at first PENABLE -> transfer=1, READ_WRITE=0,
//    apb_write_paddr=0x005, data=0xA5; rsp_valid=4'b0001, rsp_err=0.
//  2 req1 read addr 0x105, slave1 returns 0x3C after 2 wait states -> apb_read_paddr=0x105,
//    rsp_valid=4'b0010, rsp_rdata=0x3C, rsp_err=0.
//  3 all four req_valid held, re-raised after each grant -> grant order 0,1,2,3,0; one transfer at a time.
//  4 req2 write, PSLVERR=1 at completion -> rsp_valid=4'b0100, rsp_err=1, rsp_timeout=0.
//  5 req3 read, PREADY stuck 0 -> after 16 BUSY cycles transfer=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//  6 PRESETn low during BUSY of req2 -> all outputs 0 asynchronously; after release, req0+req2 valid -> req0 granted.

Source files
------------

// File: rtl/apb_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_sched_pkg
//  Description : Shared widths, direction encodings and FSM state type for
//                the APB requester scheduler.
//  Contents    : ADDR_W / DATA_W        bridge user-port widths
//                RW_READ / RW_WRITE     READ_WRITE encoding toward the bridge
//                sched_state_t          IDLE -> BUSY -> RESP
//  Revision    : 1.0  initial release
// ============================================================================
package apb_sched_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches the request
//                vector starting one past the last granted index and wrapping
//                modulo N; the first set bit wins.
//  Ports       : req         in   N       pending requests
//                last_ptr    in   IDX_W   index granted most recently
//                grant       out  N       one-hot winner (0 when no request)
//                grant_idx   out  IDX_W   binary index of the winner
//                grant_valid out  1       at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin
        int               w_pos;
        logic [IDX_W-1:0] w_cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_pos       = 0;
        w_cand      = '0;
        // k runs 1..N so the last-granted requester is considered last.
        for (int k = 1; k <= N; k++) begin
            w_pos  = (int'(last_ptr) + k) % N;
            w_cand = IDX_W'(w_pos);
            if (!grant_valid && req[w_cand]) begin
                grant_valid   = 1'b1;
                grant_idx     = w_cand;
                grant[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : apb_req_scheduler
//  Description : Shares the APB bridge user port between NREQ requesters.
//                Round-robin arbitration, one transfer in flight, completion
//                observed on the bus (PENABLE & PREADY), per-requester
//                response pulse, and a bus-hang timeout.
//  Ports       : PCLK, PRESETn          clock / async active-low reset
//                req_valid/write        per-requester request + direction
//                req_addr/req_wdata     packed per-requester address / data
//                req_grant              one-hot grant pulse (first BUSY cycle)
//                rsp_valid              one-hot completion pulse (RESP cycle)
//                rsp_rdata/err/timeout  response payload, held until next RESP
//                transfer, READ_WRITE   bridge control
//                apb_write_paddr/data   bridge write side (0 during reads)
//                apb_read_paddr         bridge read side (0 during writes)
//                PENABLE/PREADY/PSLVERR bus monitor taps
//                apb_read_data_out      read data from bridge
//  Revision    : 1.0  initial release
// ============================================================================
module apb_req_scheduler
    import apb_sched_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_grant,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic                   transfer,
    output logic                   READ_WRITE,
    output logic [ADDR_W-1:0]      apb_write_paddr,
    output logic [DATA_W-1:0]      apb_write_data,
    output logic [ADDR_W-1:0]      apb_read_paddr,
    input  logic                   PENABLE,
    input  logic                   PREADY,
    input  logic                   PSLVERR,
    input  logic [DATA_W-1:0]      apb_read_data_out
);

    localparam int c_IDX_W   = $clog2(NREQ);
    // Timer only has to reach TIMEOUT_CYCLES-1.
    localparam int c_TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST =
        c_TIMER_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [NREQ-1:0] c_ONE = NREQ'(1);

    sched_state_t          r_state;
    logic [c_IDX_W-1:0]    r_ptr;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_write;
    logic [c_TIMER_W-1:0]  r_timer;

    logic [NREQ-1:0]       r_grant;
    logic [NREQ-1:0]       r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  r_transfer;
    logic                  r_read_write;
    logic [ADDR_W-1:0]     r_wr_paddr;
    logic [DATA_W-1:0]     r_wr_data;
    logic [ADDR_W-1:0]     r_rd_paddr;

    logic [NREQ-1:0]       w_arb_grant;
    logic [c_IDX_W-1:0]    w_arb_idx;
    logic                  w_arb_valid;
    logic                  w_sel_write;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic                  w_complete;
    logic                  w_expire;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .req         (req_valid),
        .last_ptr    (r_ptr),
        .grant       (w_arb_grant),
        .grant_idx   (w_arb_idx),
        .grant_valid (w_arb_valid)
    );

    assign w_sel_write = req_write[w_arb_idx];
    assign w_sel_addr  = req_addr[w_arb_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[w_arb_idx*DATA_W +: DATA_W];

    // Completion has priority over a timeout landing on the same edge.
    assign w_complete = PENABLE & PREADY;
    assign w_expire   = c_TIMEOUT_EN && (r_timer == c_TIMER_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= IDLE;
            r_ptr         <= c_IDX_W'(NREQ - 1);
            r_idx         <= '0;
            r_write       <= 1'b0;
            r_timer       <= '0;
            r_grant       <= '0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_transfer    <= 1'b0;
            r_read_write  <= 1'b0;
            r_wr_paddr    <= '0;
            r_wr_data     <= '0;
            r_rd_paddr    <= '0;
        end else begin
            r_grant     <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_idx        <= w_arb_idx;
                        r_write      <= w_sel_write;
                        r_timer      <= '0;
                        r_grant      <= w_arb_grant;
                        r_transfer   <= 1'b1;
                        r_read_write <= w_sel_write ? RW_WRITE : RW_READ;
                        r_wr_paddr   <= w_sel_write ? w_sel_addr  : '0;
                        r_wr_data    <= w_sel_write ? w_sel_wdata : '0;
                        r_rd_paddr   <= w_sel_write ? '0 : w_sel_addr;
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_complete || w_expire) begin
                        r_rsp_valid   <= c_ONE << r_idx;
                        r_rsp_rdata   <= (w_complete && !r_write) ? apb_read_data_out : '0;
                        r_rsp_err     <= w_complete ? PSLVERR : 1'b1;
                        r_rsp_timeout <= !w_complete;
                        // Dropping transfer here forces an idle gap at the bridge.
                        r_transfer    <= 1'b0;
                        r_read_write  <= 1'b0;
                        r_wr_paddr    <= '0;
                        r_wr_data     <= '0;
                        r_rd_paddr    <= '0;
                        r_state       <= RESP;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                RESP: begin
                    r_ptr   <= r_idx;
                    r_timer <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_grant       = r_grant;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;
    assign rsp_timeout     = r_rsp_timeout;
    assign transfer        = r_transfer;
    assign READ_WRITE      = r_read_write;
    assign apb_write_paddr = r_wr_paddr;
    assign apb_write_data  = r_wr_data;
    assign apb_read_paddr  = r_rd_paddr;

endmodule
`default_nettype wire
